// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns decoded descriptors back into 32-bit words
// and streams them into instruction memory one word at a time.
module instr_encoder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hBFC00000,
    parameter int                    DEPTH      = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   kind,
    input  logic [2:0]                   alu_sel,
    input  logic                         byte_mode,
    input  logic                         branch_ne,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic [31:0]                  imm,
    output logic                         wr_en,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [31:0]                  wr_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         err
);

    localparam int CW = $clog2(DEPTH+1);

    localparam logic [2:0] K_OPIMM  = 3'd0;
    localparam logic [2:0] K_LOAD   = 3'd1;
    localparam logic [2:0] K_STORE  = 3'd2;
    localparam logic [2:0] K_OP     = 3'd3;
    localparam logic [2:0] K_BRANCH = 3'd4;
    localparam logic [2:0] K_JALR   = 3'd5;
    localparam logic [2:0] K_JAL    = 3'd6;
    localparam logic [2:0] K_LUI    = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FULL
    } state_t;

    state_t state_q, state_d;

    logic [2:0]  f3_alu;
    logic        alu_ok;
    logic        is_sll;
    logic        is_sub;
    logic [31:0] enc;
    logic        legal;
    logic        accept;
    logic        last;

    always_comb begin
        f3_alu = 3'b000;
        alu_ok = 1'b1;
        unique case (alu_sel)
            3'b000:  f3_alu = 3'b000;
            3'b001:  f3_alu = 3'b000;
            3'b010:  f3_alu = 3'b111;
            3'b011:  f3_alu = 3'b110;
            3'b100:  f3_alu = 3'b001;
            3'b101:  f3_alu = 3'b010;
            default: alu_ok = 1'b0;
        endcase
    end

    assign is_sll = (alu_sel == 3'b100);
    assign is_sub = (alu_sel == 3'b001);

    always_comb begin
        enc   = 32'h0;
        legal = 1'b1;
        unique case (kind)
            K_OPIMM: begin
                // shifts carry only the 5-bit shamt; upper imm bits are dropped
                if (is_sll)
                    enc = {7'b0, imm[4:0], rs1, f3_alu, rd, 7'b0010011};
                else
                    enc = {imm[11:0], rs1, f3_alu, rd, 7'b0010011};
                legal = alu_ok && !is_sub;
            end
            K_OP: begin
                enc = {1'b0, is_sub, 5'b0, rs2, rs1, f3_alu, rd,
                       7'b0110011};
                legal = alu_ok;
            end
            K_LOAD: begin
                enc = {imm[11:0], rs1, byte_mode ? 3'b100 : 3'b010, rd,
                       7'b0000011};
            end
            K_STORE: begin
                enc = {imm[11:5], rs2, rs1, byte_mode ? 3'b000 : 3'b010,
                       imm[4:0], 7'b0100011};
            end
            K_BRANCH: begin
                enc = {imm[12], imm[10:5], rs2, rs1, 2'b00, branch_ne,
                       imm[4:1], imm[11], 7'b1100011};
                legal = !imm[0];
            end
            K_JALR: begin
                enc = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            end
            K_JAL: begin
                enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd,
                       7'b1101111};
                legal = !imm[0];
            end
            K_LUI: begin
                enc = {imm[31:12], rd, 7'b0110111};
            end
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign wr_en    = (state_q == WRITE);
    assign full     = (state_q == FULL);
    assign accept   = in_valid && in_ready && !clear;
    assign last     = (count == CW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && legal) state_d = WRITE;
            WRITE:   state_d = last ? FULL : IDLE;
            FULL:    state_d = FULL;
            default: state_d = IDLE;
        endcase
        if (clear)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= BASE_ADDR;
            wr_data <= 32'h0;
            count   <= '0;
            err     <= 1'b0;
        end else if (clear) begin
            wr_addr <= BASE_ADDR;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            if (accept && legal)
                wr_data <= enc;
            if (accept && !legal)
                err <= 1'b1;
            if (state_q == WRITE) begin
                wr_addr <= wr_addr + ADDR_WIDTH'(4);
                count   <= count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_instr_encoder;

    localparam int          AW    = 32;
    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH+1);

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    kind;
    logic [2:0]    alu_sel;
    logic          byte_mode;
    logic          branch_ne;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [CW-1:0] count;
    logic          full;
    logic          err;

    instr_encoder #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kind      (kind),
        .alu_sel   (alu_sel),
        .byte_mode (byte_mode),
        .branch_ne (branch_ne),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .count     (count),
        .full      (full),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [2:0]  alu;
        logic        bm;
        logic        bn;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] k, input logic [2:0] a,
                                input logic b, input logic n,
                                input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [31:0] i,
                                input bit lg, input logic [31:0] w);
        vec_t v;
        v.kind = k; v.alu = a; v.bm = b; v.bn = n;
        v.rd = d; v.rs1 = s1; v.rs2 = s2; v.imm = i;
        v.legal = lg; v.word = w;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        kind = v.kind; alu_sel = v.alu; byte_mode = v.bm;
        branch_ne = v.bn; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        imm = v.imm;
    endtask

    // reference encoding built from field positions with plain arithmetic
    function automatic logic [31:0] ref_f3(input logic [2:0] a);
        logic [2:0] tab [6];
        tab = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd1, 3'd2};
        return (a < 6) ? 32'(tab[a]) : 32'd0;
    endfunction

    function automatic bit ref_legal(input logic [2:0] k,
                                     input logic [2:0] a,
                                     input logic [31:0] i);
        if (k == 0) return (a != 1) && (a < 6);
        if (k == 3) return a < 6;
        if (k == 4 || k == 6) return (i % 2) == 0;
        return 1;
    endfunction

    function automatic logic [31:0] ref_enc(input logic [2:0] k,
                                            input logic [2:0] a,
                                            input logic b, input logic n,
                                            input logic [4:0] d,
                                            input logic [4:0] s1,
                                            input logic [4:0] s2,
                                            input logic [31:0] i);
        logic [31:0] vd, v1, v2, w;
        vd = 32'(d) * 128;
        v1 = 32'(s1) * 32768;
        v2 = 32'(s2) * 1048576;
        w  = 0;
        case (k)
            0: w = 32'h13 + vd + ref_f3(a) * 4096 + v1 +
                   ((a == 4) ? (i % 32) : (i % 4096)) * 1048576;
            3: w = 32'h33 + vd + ref_f3(a) * 4096 + v1 + v2 +
                   ((a == 1) ? 32'h40000000 : 32'h0);
            1: w = 32'h03 + vd + (b ? 4 : 2) * 4096 + v1 +
                   (i % 4096) * 1048576;
            2: w = 32'h23 + (i % 32) * 128 + (b ? 0 : 2) * 4096 + v1 + v2 +
                   ((i / 32) % 128) * 33554432;
            4: w = 32'h63 + ((i / 2048) % 2) * 128 + ((i / 2) % 16) * 256 +
                   (n ? 4096 : 0) + v1 + v2 +
                   ((i / 32) % 64) * 33554432 +
                   ((i / 4096) % 2) * 32'h80000000;
            5: w = 32'h67 + vd + v1 + (i % 4096) * 1048576;
            6: w = 32'h6F + vd + ((i / 4096) % 256) * 4096 +
                   ((i / 2048) % 2) * 1048576 +
                   ((i / 2) % 1024) * 2097152 +
                   ((i / 1048576) % 2) * 32'h80000000;
            default: w = 32'h37 + vd + (i / 4096) * 4096;
        endcase
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1; in_valid = 1'b0;
        cyc();
        clear = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        do_clear();
        drive(v);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        if (v.legal) begin
            chk($sformatf("vec%0d_wr_en", idx), wr_en, 1);
            chk($sformatf("vec%0d_addr", idx), wr_addr, BASE);
            chk($sformatf("vec%0d_data", idx), wr_data, v.word);
            cyc();
            chk($sformatf("vec%0d_count", idx), count, 1);
            chk($sformatf("vec%0d_err", idx), err, 0);
        end else begin
            chk($sformatf("vec%0d_no_wr", idx), wr_en, 0);
            chk($sformatf("vec%0d_err", idx), err, 1);
            cyc();
            chk($sformatf("vec%0d_no_wr2", idx), wr_en, 0);
            chk($sformatf("vec%0d_count", idx), count, 0);
            chk($sformatf("vec%0d_err_hold", idx), err, 1);
        end
    endtask

    bit          exp_wr, exp_err, rdy;
    logic [31:0] exp_word, exp_addr;
    int          exp_count, writes;

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        vecs.push_back(mk(0, 3'd0, 0, 0, 1, 0, 0, 32'd5, 1, 32'h00500093));
        vecs.push_back(mk(3, 3'd1, 0, 0, 3, 1, 2, 32'd0, 1, 32'h402081B3));
        vecs.push_back(mk(2, 3'd0, 0, 0, 0, 1, 2, 32'd8, 1, 32'h0020A423));
        vecs.push_back(mk(4, 3'd0, 0, 1, 0, 1, 0, -32'sd4, 1, 32'hFE009EE3));
        vecs.push_back(mk(6, 3'd0, 0, 0, 1, 0, 0, 32'd8, 1, 32'h008000EF));
        vecs.push_back(mk(7, 3'd0, 0, 0, 5, 0, 0, 32'h12345000, 1,
                          32'h123452B7));
        vecs.push_back(mk(1, 3'd0, 1, 0, 2, 3, 0, 32'h10, 1, 32'h0101C103));
        vecs.push_back(mk(0, 3'd4, 0, 0, 4, 4, 0, 32'hFFFFFFE3, 1,
                          32'h00321213));
        vecs.push_back(mk(5, 3'd0, 0, 0, 0, 1, 0, 32'd0, 1, 32'h00008067));
        vecs.push_back(mk(3, 3'd5, 0, 0, 5, 6, 7, 32'd0, 1, 32'h007322B3));
        vecs.push_back(mk(0, 3'd2, 0, 0, 1, 1, 0, 32'hFFF, 1, 32'hFFF0F093));
        vecs.push_back(mk(0, 3'd1, 0, 0, 1, 1, 0, 32'd5, 0, 32'h0));
        vecs.push_back(mk(3, 3'd6, 0, 0, 1, 1, 2, 32'd0, 0, 32'h0));
        vecs.push_back(mk(4, 3'd0, 0, 0, 0, 1, 2, 32'd3, 0, 32'h0));
        vecs.push_back(mk(6, 3'd0, 0, 0, 1, 0, 0, 32'd1, 0, 32'h0));

        cyc();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, BASE);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        cyc();

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // back-to-back with in_valid held: sub then sw
        do_clear();
        drive(vecs[1]);
        in_valid = 1'b1;
        cyc();
        chk("seq_ready_w0", in_ready, 0);
        chk("seq_wr_en0", wr_en, 1);
        chk("seq_addr0", wr_addr, BASE);
        chk("seq_data0", wr_data, 32'h402081B3);
        drive(vecs[2]);
        cyc();
        chk("seq_ready_idle", in_ready, 1);
        chk("seq_no_wr", wr_en, 0);
        cyc();
        in_valid = 1'b0;
        chk("seq_ready_w1", in_ready, 0);
        chk("seq_wr_en1", wr_en, 1);
        chk("seq_addr1", wr_addr, BASE + 4);
        chk("seq_data1", wr_data, 32'h0020A423);
        cyc();
        chk("seq_count", count, 2);

        // fill to DEPTH with in_valid held high
        do_clear();
        drive(vecs[0]);
        in_valid = 1'b1;
        writes = 0;
        for (int c = 0; c < 14; c++) begin
            cyc();
            if (wr_en) begin
                chk("fill_addr", wr_addr, BASE + 4 * writes);
                writes++;
            end
        end
        chk("fill_writes", writes, DEPTH);
        chk("fill_full", full, 1);
        chk("fill_ready", in_ready, 0);
        chk("fill_count", count, DEPTH);
        do_clear();
        chk("clr_addr", wr_addr, BASE);
        chk("clr_count", count, 0);
        chk("clr_ready", in_ready, 1);
        chk("clr_full", full, 0);

        // sticky err across a legal write, then async reset mid-write
        do_clear();
        drive(vecs[11]);
        in_valid = 1'b1;
        cyc();
        drive(vecs[0]);
        cyc();
        in_valid = 1'b0;
        chk("sticky_wr_en", wr_en, 1);
        chk("sticky_err", err, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", wr_en, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_addr", wr_addr, BASE);
        chk("arst_data", wr_data, 0);
        chk("arst_count", count, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("arst_stay", wr_en, 0);

        // clear wins over a same-cycle handshake
        drive(vecs[0]);
        clear = 1'b1; in_valid = 1'b1;
        cyc();
        clear = 1'b0; in_valid = 1'b0;
        chk("clrhs_no_wr", wr_en, 0);
        chk("clrhs_ready", in_ready, 1);
        cyc();
        chk("clrhs_no_wr2", wr_en, 0);
        chk("clrhs_count", count, 0);

        // randomized run against the transaction model
        do_clear();
        exp_wr = 0; exp_err = 0; exp_addr = BASE; exp_count = 0;
        exp_word = 0;
        for (int i = 0; i < 3000; i++) begin
            rdy = !exp_wr && exp_count < DEPTH;
            chk("rnd_ready", in_ready, rdy);
            chk("rnd_wr_en", wr_en, exp_wr);
            if (exp_wr) begin
                chk("rnd_addr", wr_addr, exp_addr);
                chk("rnd_data", wr_data, exp_word);
            end
            chk("rnd_count", count, exp_count);
            chk("rnd_full", full, exp_count == DEPTH);
            chk("rnd_err", err, exp_err);

            clear     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            kind      = 3'($urandom);
            alu_sel   = 3'($urandom);
            byte_mode = 1'($urandom);
            branch_ne = 1'($urandom);
            rd        = 5'($urandom);
            rs1       = 5'($urandom);
            rs2       = 5'($urandom);
            imm       = $urandom;
            if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;

            if (clear) begin
                exp_wr = 0; exp_addr = BASE; exp_count = 0; exp_err = 0;
            end else if (exp_wr) begin
                exp_wr = 0; exp_addr += 4; exp_count++;
            end else if (rdy && in_valid) begin
                if (ref_legal(kind, alu_sel, imm)) begin
                    exp_wr   = 1;
                    exp_word = ref_enc(kind, alu_sel, byte_mode, branch_ne,
                                       rd, rs1, rs2, imm);
                end else begin
                    exp_err = 1;
                end
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
